// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryption core, one round per clock, fed by an external
// round-key store addressed through rkey_addr with a same-cycle rkey read.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign q = SBOX[a];
endmodule

module aes_enc_iter #(
  parameter int NR_MAX = 14
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      aes_mode,
  input  logic                            key_rdy,
  output logic [$clog2(NR_MAX+1)-1:0]     rkey_addr,
  input  logic [127:0]                    rkey,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [127:0]                    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [127:0]                    out_data,
  output logic                            abort
);
  localparam int RW = $clog2(NR_MAX+1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t          fsm, fsm_next;
  logic [127:0]  blk;
  logic [RW-1:0] round, nr;
  logic          accept, last_round;
  logic [127:0]  sub_vec, sr_vec, mc_vec;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [RW-1:0] rounds_for(input logic [1:0] mode);
    case (mode)
      2'b00:   return RW'(10);
      2'b01:   return RW'(12);
      default: return RW'(14);
    endcase
  endfunction

  // Byte k of the block lives at [127-8k -: 8]; bytes are column-major (row r, column c -> r+4c).
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (.a(blk[127-8*i -: 8]), .q(sub_vec[127-8*i -: 8]));
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr_vec[127-8*(r+4*c) -: 8] = sub_vec[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_vec[127-32*c -: 8];
    assign a1 = sr_vec[119-32*c -: 8];
    assign a2 = sr_vec[111-32*c -: 8];
    assign a3 = sr_vec[103-32*c -: 8];
    assign mc_vec[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end

  assign accept     = (fsm == IDLE) && in_valid && in_ready;
  assign last_round = (round == nr);

  // A falling key_rdy in ROUND wins over the final round: the key store can no longer be trusted.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm      <= IDLE;
      blk      <= '0;
      round    <= '0;
      nr       <= '0;
      out_data <= '0;
      abort    <= 1'b0;
    end else begin
      fsm   <= fsm_next;
      abort <= (fsm == ROUND) && !key_rdy;
      case (fsm)
        IDLE: begin
          if (accept) begin
            blk   <= in_data ^ rkey;
            nr    <= rounds_for(aes_mode);
            round <= RW'(1);
          end
        end
        ROUND: begin
          if (!key_rdy) begin
            blk   <= '0;
            round <= '0;
          end else if (last_round) begin
            out_data <= sr_vec ^ rkey;
            round    <= '0;
          end else begin
            blk   <= mc_vec ^ rkey;
            round <= round + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_next = ROUND;
      ROUND: begin
        if (!key_rdy)        fsm_next = IDLE;
        else if (last_round) fsm_next = DONE;
      end
      DONE:    if (out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // in_ready is held low while reset is asserted so nothing can look acceptable during reset.
  always_comb begin
    in_ready  = !reset && (fsm == IDLE) && key_rdy && (aes_mode != 2'b11);
    rkey_addr = (fsm == ROUND) ? round : '0;
    out_valid = (fsm == DONE);
  end
endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: models the round-key store, a byte-level AES reference and the
// block handshake, and checks the DUT against it every cycle plus directed known-answer vectors.

module tb_aes_enc_iter;
  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   aes_mode;
  logic         key_rdy;
  logic [3:0]   rkey_addr;
  logic [127:0] rkey;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         abort;

  logic [127:0] rk_mem [16];
  logic [7:0]   sbox_t [256];
  int           n_tests = 0;
  int           n_fail  = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K_B    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_enc_iter dut (
    .clk(clk), .reset(reset), .aes_mode(aes_mode), .key_rdy(key_rdy),
    .rkey_addr(rkey_addr), .rkey(rkey), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .abort(abort)
  );

  always #5 clk = ~clk;

  assign rkey = rk_mem[rkey_addr];

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subword(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_mem[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++) t[row+4*col] = s[row + 4*((col+row)%4)];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          s[row+4*col] = (r == nr) ? t[row+4*col] :
                         gmul(8'h02, t[row+4*col]) ^ gmul(8'h03, t[(row+1)%4+4*col]) ^
                         t[(row+2)%4+4*col] ^ t[(row+3)%4+4*col];
      for (int i = 0; i < 16; i++) s[i] ^= rk_mem[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Cycle-level reference of the handshake, stepped on the falling edge with the inputs
  // that the next rising edge will see.
  initial begin
    bit           m_busy = 0, m_held = 0, m_abort = 0, rdy_exp;
    int           m_count = 0, m_nr = 0;
    logic [127:0] m_ct = '0, m_out = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      rdy_exp = !reset && !m_busy && !m_held && key_rdy && aes_mode != 2'b11;
      check_output("cmp_out_valid", 128'(out_valid), 128'(m_held));
      check_output("cmp_out_data", out_data, m_out);
      check_output("cmp_abort", 128'(abort), 128'(m_abort));
      check_output("cmp_in_ready", 128'(in_ready), 128'(rdy_exp));
      check_output("cmp_rkey_addr", 128'(rkey_addr), 128'(m_busy ? m_count : 0));
      if (reset) begin
        m_busy = 0; m_held = 0; m_abort = 0; m_count = 0; m_out = '0;
      end else begin
        m_abort = 0;
        if (m_busy) begin
          if (!key_rdy) begin
            m_busy = 0; m_abort = 1;
          end else if (m_count == m_nr) begin
            m_busy = 0; m_held = 1; m_out = m_ct;
          end else begin
            m_count++;
          end
        end else if (m_held) begin
          if (out_ready) m_held = 0;
        end else if (in_valid && rdy_exp) begin
          m_busy  = 1;
          m_count = 1;
          m_nr    = 10 + 2*int'(aes_mode);
          m_ct    = aes_model(in_data, m_nr);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [255:0] key, input int nk, input logic [1:0] mode);
    key_rdy  = 1'b0;
    aes_mode = mode;
    @(posedge clk); #1;
    check_output("in_ready_no_key", 128'(in_ready), 128'(0));
    load_key(key, nk);
    key_rdy = 1'b1;
  endtask

  task automatic start_block(input logic [127:0] pt);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check_output("accept_wait", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = pt;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] pt, input int nr, input logic [127:0] ct, input int hold);
    int         cyc = 0;
    logic [1:0] saved_mode = aes_mode;
    start_block(pt);
    in_valid = 1'b1;
    in_data  = ~pt;
    aes_mode = 2'b11;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_output("latency", 128'(cyc), 128'(nr));
    check_output("ciphertext", out_data, ct);
    in_valid = 1'b0;
    aes_mode = saved_mode;
    repeat (hold) begin
      @(posedge clk); #1;
      check_output("hold_valid", 128'(out_valid), 128'(1));
      check_output("hold_in_ready", 128'(in_ready), 128'(0));
      check_output("hold_data", out_data, ct);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output("release_valid", 128'(out_valid), 128'(0));
    check_output("release_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    reset = 1'b1; key_rdy = 1'b0; aes_mode = 2'b00;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    build_sbox();
    check_output("sbox_00", 128'(sbox_t[8'h00]), 128'(8'h63));
    check_output("sbox_53", 128'(sbox_t[8'h53]), 128'(8'hed));
    check_output("sbox_ff", 128'(sbox_t[8'hff]), 128'(8'h16));

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_out_valid", 128'(out_valid), 128'(0));
    check_output("rst_out_data", out_data, 128'(0));
    check_output("rst_rkey_addr", 128'(rkey_addr), 128'(0));
    check_output("rst_abort", 128'(abort), 128'(0));
    check_output("rst_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b0;

    apply_stimulus(K128, 4, 2'b00);
    check_output("model_aes128", aes_model(PT, 10), CT128);
    run_block(PT, 10, CT128, 0);

    apply_stimulus(K_B, 4, 2'b00);
    check_output("model_fips_b", aes_model(PT_B, 10), CT_B);
    run_block(PT_B, 10, CT_B, 0);

    apply_stimulus(K192, 6, 2'b01);
    check_output("model_aes192", aes_model(PT, 12), CT192);
    run_block(PT, 12, CT192, 0);

    apply_stimulus(K256, 8, 2'b10);
    check_output("model_aes256", aes_model(PT, 14), CT256);
    run_block(PT, 14, CT256, 20);
    run_block(PT, 14, CT256, 0);

    aes_mode = 2'b11;
    in_valid = 1'b1;
    in_data  = PT;
    repeat (5) begin
      @(posedge clk); #1;
      check_output("reserved_in_ready", 128'(in_ready), 128'(0));
      check_output("reserved_rkey_addr", 128'(rkey_addr), 128'(0));
    end
    in_valid = 1'b0;

    apply_stimulus(K128, 4, 2'b00);
    start_block(PT);
    w = 0;
    while (rkey_addr != 4'd5 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_output("abort_reach_r5", 128'(rkey_addr), 128'(5));
    key_rdy = 1'b0;
    @(posedge clk); #1;
    check_output("abort_pulse", 128'(abort), 128'(1));
    check_output("abort_no_valid", 128'(out_valid), 128'(0));
    check_output("abort_rkey_addr", 128'(rkey_addr), 128'(0));
    check_output("abort_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    check_output("abort_one_cycle", 128'(abort), 128'(0));
    repeat (15) @(posedge clk);
    #1;
    check_output("abort_still_no_valid", 128'(out_valid), 128'(0));
    key_rdy = 1'b1;

    start_block(PT);
    w = 0;
    while (rkey_addr != 4'd7 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_output("reset_reach_r7", 128'(rkey_addr), 128'(7));
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("midreset_out_valid", 128'(out_valid), 128'(0));
    check_output("midreset_rkey_addr", 128'(rkey_addr), 128'(0));
    check_output("midreset_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b0;
    run_block(PT, 10, CT128, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
